// File: rtl/bp_table_ctrl.sv
// Branch-prediction table controller: direct-mapped BTB with a 2-bit BHT counter
// per entry, combinational IF lookup, EX-driven update, clear sweep and statistics.
module bp_table_ctrl #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        BTBF,
  output logic        BHTF,
  output logic [31:0] BTB_Target,
  input  logic        UpdE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        BTBE,
  input  logic        BHTE,
  output logic        Pred_True,
  input  logic        FlushBP,
  output logic        Ready,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]     tag_mem [DEPTH];
  logic [31:0]          tgt_mem [DEPTH];
  logic [1:0]           cnt_mem [DEPTH];

  logic [INDEX_W-1:0]   idx_f, idx_e, wr_idx;
  logic [TAG_W-1:0]     tag_f, tag_e, wr_tag;
  logic [31:0]          wr_tgt;
  logic [1:0]           wr_cnt, cnt_e;
  logic                 wr_en, wr_valid, hit_f, hit_e;
  logic                 pc_lsb_unused;

  assign idx_f = PCF[INDEX_W+1:2];
  assign tag_f = PCF[31:INDEX_W+2];
  assign idx_e = PCE[INDEX_W+1:2];
  assign tag_e = PCE[31:INDEX_W+2];
  assign cnt_e = cnt_mem[idx_e];
  assign pc_lsb_unused = ^{PCF[1:0], PCE[1:0]};

  // Lookup is suppressed during the sweep because payload arrays may hold stale data.
  assign hit_f      = (state_q == ST_RUN) & valid_q[idx_f] & (tag_mem[idx_f] == tag_f);
  assign BTBF       = hit_f;
  assign BHTF       = hit_f & cnt_mem[idx_f][1];
  assign BTB_Target = hit_f ? tgt_mem[idx_f] : 32'h0;

  assign hit_e     = valid_q[idx_e] & (tag_mem[idx_e] == tag_e);
  assign Pred_True = UpdE & ((BTBE & BHTE) == BranchE);
  assign Ready     = (state_q == ST_RUN);
  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    wr_valid = 1'b0;
    wr_tag   = '0;
    wr_tgt   = 32'h0;
    wr_cnt   = 2'b01;

    case (state_q)
      ST_INIT: begin
        wr_en = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == {INDEX_W{1'b1}}) state_d = ST_RUN;
      end
      default: begin
        if (UpdE) begin
          wr_idx   = idx_e;
          wr_valid = 1'b1;
          wr_tag   = tag_e;
          wr_tgt   = BranchTargetE;
          if (hit_e) begin
            wr_en = 1'b1;
            if (BranchE) begin
              wr_cnt = (cnt_e == 2'b11) ? 2'b11 : cnt_e + 2'b01;
            end else begin
              wr_cnt = (cnt_e == 2'b00) ? 2'b00 : cnt_e - 2'b01;
              wr_tgt = tgt_mem[idx_e];
            end
          end else if (BranchE) begin
            wr_en  = 1'b1;
            wr_cnt = 2'b10;
          end
        end
      end
    endcase

    // Flush wins over a same-cycle update; during INIT the pending clear write is harmless.
    if (FlushBP) begin
      state_d = ST_INIT;
      idx_d   = '0;
      if (state_q == ST_RUN) wr_en = 1'b0;
    end

    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = wr_valid;

    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (UpdE && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (UpdE && !Pred_True && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      valid_q      <= '0;
      branch_cnt_q <= 32'h0;
      miss_cnt_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // NOTE: payload arrays have no reset; the valid bits and the INIT sweep make them safe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_tgt;
      cnt_mem[wr_idx] <= wr_cnt;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: directed scenarios plus randomized traffic
// compared against a whole-table behavioural model.
module tb_bp_table_ctrl;

  localparam int IW    = 6;
  localparam int DEPTH = 64;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF, PCE, BranchTargetE;
  logic        UpdE, BranchE, BTBE, BHTE, FlushBP;
  logic        BTBF, BHTF, Pred_True, Ready;
  logic [31:0] BTB_Target, BranchCnt, MissCnt;

  bp_table_ctrl #(.INDEX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .BTBF(BTBF), .BHTF(BHTF),
    .BTB_Target(BTB_Target), .UpdE(UpdE), .PCE(PCE), .BranchE(BranchE),
    .BranchTargetE(BranchTargetE), .BTBE(BTBE), .BHTE(BHTE),
    .Pred_True(Pred_True), .FlushBP(FlushBP), .Ready(Ready),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: table contents, cycles left until the table is usable, statistics.
  bit          m_valid [DEPTH];
  logic [23:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_cnt   [DEPTH];
  int          m_left;
  longint      m_bc, m_mc;

  function automatic int ix(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return (m_left == 0) && m_valid[ix(pc)] && (m_tag[ix(pc)] == pc[31:8]);
  endfunction

  function automatic logic [33:0] exp_look(input logic [31:0] pc);
    bit h;
    h = m_hit(pc);
    return {h, h && (m_cnt[ix(pc)] >= 2), h ? m_tgt[ix(pc)] : 32'h0};
  endfunction

  function automatic bit exp_pred();
    return UpdE && ((BTBE & BHTE) == BranchE);
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_left = DEPTH;
    m_bc   = 0;
    m_mc   = 0;
  endtask

  // Apply the model's view of one rising edge, then advance the DUT to edge+1.
  task automatic tick();
    bit h;
    int k;
    h = m_hit(PCE);
    k = ix(PCE);
    if (UpdE) begin
      if (m_bc < MAXC) m_bc++;
      if (!exp_pred() && m_mc < MAXC) m_mc++;
    end
    if (FlushBP) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_left = DEPTH;
    end else if (m_left > 0) begin
      m_left--;
    end else if (UpdE) begin
      if (h) begin
        if (BranchE) begin
          m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
          m_tgt[k] = BranchTargetE;
        end else begin
          m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
        end
      end else if (BranchE) begin
        m_valid[k] = 1'b1;
        m_tag[k]   = PCE[31:8];
        m_tgt[k]   = BranchTargetE;
        m_cnt[k]   = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    UpdE = 0; BranchE = 0; BTBE = 0; BHTE = 0; FlushBP = 0;
    PCE = 32'h0; BranchTargetE = 32'h0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] t;
    logic [5:0]  i;
    case ($urandom_range(0, 3))
      0: t = 24'h000001;
      1: t = 24'h000002;
      2: t = 24'hABCDEF;
      default: t = 24'hFFFFFF;
    endcase
    i = ($urandom_range(0, 4) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
    return {t, i, 2'b00};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    PCF = 32'h0000_0100;
    model_reset();
    #1;
    total++;
    if (Ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", Ready); end
    total++;
    if ({BTBF, BHTF, BTB_Target} !== 34'h0) begin
      bad++; $display("FAIL reset_lookup got=%0b/%0b/%h exp=0/0/0", BTBF, BHTF, BTB_Target);
    end
    total++;
    if (BranchCnt !== 32'h0 || MissCnt !== 32'h0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", BranchCnt, MissCnt);
    end
    total++;
    if (Pred_True !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0b exp=0", Pred_True); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      PCF = rand_pc();
      #1;
      total++;
      if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
        bad++; $display("FAIL init_lookup cyc=%0d got=%0b/%h exp=0/0", i, BTBF, BTB_Target);
      end
      tick();
      total++;
      if (Ready !== (m_left == 0)) begin
        bad++; $display("FAIL init_ready edge=%0d got=%0b exp=%0b", i, Ready, m_left == 0);
      end
    end
  endtask

  task automatic test_alloc();
    UpdE = 1; PCE = 32'h100; BranchE = 1; BranchTargetE = 32'h200; BTBE = 0; BHTE = 0;
    PCF = 32'h100;
    #1;
    total++;
    if (Pred_True !== exp_pred()) begin
      bad++; $display("FAIL alloc_pred got=%0b exp=%0b", Pred_True, exp_pred());
    end
    total++;
    if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
      bad++; $display("FAIL alloc_nobypass got=%0b/%0b/%h exp=miss", BTBF, BHTF, BTB_Target);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (BranchCnt !== 32'(m_bc) || MissCnt !== 32'(m_mc)) begin
      bad++; $display("FAIL alloc_stats got=%0d/%0d exp=%0d/%0d", BranchCnt, MissCnt, m_bc, m_mc);
    end
    total++;
    if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
      bad++; $display("FAIL alloc_lookup got=%0b/%0b/%h exp=%h", BTBF, BHTF, BTB_Target, exp_look(PCF));
    end
  endtask

  task automatic test_not_taken();
    for (int n = 0; n < 3; n++) begin
      UpdE = 1; PCE = 32'h100; BranchE = 0; BranchTargetE = 32'hDEAD_0000;
      BTBE = BTBF; BHTE = BHTF; PCF = 32'h100;
      tick();
      idle_inputs();
      #1;
      total++;
      if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
        bad++;
        $display("FAIL not_taken_%0d got=%0b/%0b/%h exp=%h", n, BTBF, BHTF, BTB_Target, exp_look(PCF));
      end
    end
  endtask

  task automatic test_alias();
    UpdE = 1; BranchE = 1; BranchTargetE = 32'h300; BTBE = 0; BHTE = 0;
    PCE = 32'h100;
    tick();
    PCE = 32'h200;
    tick();
    idle_inputs();
    PCF = 32'h100;
    #1;
    total++;
    if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
      bad++; $display("FAIL alias_old got=%0b/%h exp=miss", BTBF, BTB_Target);
    end
    PCF = 32'h200;
    #1;
    total++;
    if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
      bad++; $display("FAIL alias_new got=%0b/%0b/%h exp=%h", BTBF, BHTF, BTB_Target, exp_look(PCF));
    end
  endtask

  task automatic test_flush_update();
    FlushBP = 1; UpdE = 1; PCE = 32'h400; BranchE = 1; BranchTargetE = 32'h500;
    BTBE = 0; BHTE = 0;
    tick();
    idle_inputs();
    total++;
    if (BranchCnt !== 32'(m_bc)) begin
      bad++; $display("FAIL flush_branchcnt got=%0d exp=%0d", BranchCnt, m_bc);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      total++;
      if (Ready !== (m_left == 0)) begin
        bad++; $display("FAIL flush_ready step=%0d got=%0b exp=%0b", i, Ready, m_left == 0);
      end
      if (i < DEPTH) tick();
    end
    PCF = 32'h400;
    #1;
    total++;
    if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
      bad++; $display("FAIL flush_noalloc got=%0b/%h exp=miss", BTBF, BTB_Target);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      UpdE          = ($urandom_range(0, 2) != 0);
      PCE           = rand_pc();
      BranchE       = 1'($urandom);
      BranchTargetE = $urandom;
      BTBE          = 1'($urandom);
      BHTE          = 1'($urandom);
      FlushBP       = ($urandom_range(0, 99) == 0);
      PCF           = ($urandom_range(0, 1) == 0) ? PCE : rand_pc();
      #1;
      total++;
      if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
        bad++;
        $display("FAIL rand_lookup n=%0d pc=%h got=%0b/%0b/%h exp=%h", n, PCF, BTBF, BHTF, BTB_Target, exp_look(PCF));
      end
      total++;
      if (Pred_True !== exp_pred()) begin
        bad++; $display("FAIL rand_pred n=%0d got=%0b exp=%0b", n, Pred_True, exp_pred());
      end
      tick();
      total++;
      if (Ready !== (m_left == 0) || BranchCnt !== 32'(m_bc) || MissCnt !== 32'(m_mc)) begin
        bad++;
        $display("FAIL rand_state n=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", n, Ready, BranchCnt, MissCnt, m_left == 0, m_bc, m_mc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    UpdE = 1; PCE = 32'h0000_0A00; BranchE = 1; BranchTargetE = 32'h0BAD_0000;
    FlushBP = (m_left != 0);
    tick();
    idle_inputs();
    if (m_left != 0) begin
      FlushBP = 1;
      tick();
      FlushBP = 0;
      repeat (30) tick();
    end else begin
      FlushBP = 1;
      tick();
      FlushBP = 0;
      repeat (30) tick();
    end
    UpdE = 1; PCE = 32'h100; BranchE = 1;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (Ready !== 1'b0 || BranchCnt !== 32'h0 || MissCnt !== 32'h0) begin
      bad++; $display("FAIL midreset_state got=%0b/%0d/%0d exp=0/0/0", Ready, BranchCnt, MissCnt);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      total++;
      if (Ready !== (m_left == 0)) begin
        bad++; $display("FAIL midreset_ready edge=%0d got=%0b exp=%0b", i, Ready, m_left == 0);
      end
    end
    PCF = 32'h0000_0A00;
    #1;
    total++;
    if ({BTBF, BHTF, BTB_Target} !== exp_look(PCF)) begin
      bad++; $display("FAIL midreset_cleared got=%0b/%h exp=miss", BTBF, BTB_Target);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_not_taken();
    test_alias();
    test_flush_update();
    test_random();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
